// File: rtl/mem_traverse_gen_if.sv
// Handshake and address bus between a traversal controller and mem_traverse_gen.
// The sequencer takes the slave modport; the controller or sink takes master.
interface mem_traverse_gen_if #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8,
  parameter int BAND_W = 4
);
  localparam int ADDR_W = BAND_W + ROW_W + COL_W;

  logic              start;
  logic              abort;
  logic              step;
  logic              col_major;
  logic [BAND_W-1:0] band_first;
  logic [BAND_W-1:0] band_last;

  logic              busy;
  logic              valid;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BAND_W-1:0] band;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              wrap_row;
  logic              wrap_band;
  logic              done;
  logic              err;

  modport master (
    output start, abort, step, col_major, band_first, band_last,
    input  busy, valid, col, row, band, addr, last, wrap_row, wrap_band, done, err
  );

  modport slave (
    input  start, abort, step, col_major, band_first, band_last,
    output busy, valid, col, row, band, addr, last, wrap_row, wrap_band, done, err
  );
endinterface

// File: rtl/mem_traverse_gen.sv
// Band/row/column address sequencer: one element per accepted step, row- or column-major.
// Define MEM_TRAVERSE_SERPENTINE_EN to reverse the inner axis on odd outer indices.
module mem_traverse_gen #(
  parameter int COL_W    = 8,
  parameter int ROW_W    = 8,
  parameter int BAND_W   = 4,
  parameter int NUM_COLS = 256,
  parameter int NUM_ROWS = 256,
  parameter int ADDR_W   = BAND_W + ROW_W + COL_W
) (
  input logic               clk,
  input logic               reset,
  mem_traverse_gen_if.slave tif
);

  localparam int IDX_W = (COL_W > ROW_W) ? COL_W : ROW_W;
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(NUM_COLS - 1);
  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [BAND_W-1:0] band_last_q;
  logic              cm_q;
  logic              wrap_row_q, wrap_band_q, done_q, err_q;

  // Inner/outer view of the indices so one datapath serves both scan orders.
  logic [IDX_W-1:0] in_cur, out_cur, in_max, out_max, in_end, in_nxt, out_nxt;
  logic             in_wrap, out_wrap, at_last;

  always_comb begin
    in_cur  = cm_q ? IDX_W'(row_q) : IDX_W'(col_q);
    out_cur = cm_q ? IDX_W'(col_q) : IDX_W'(row_q);
    in_max  = cm_q ? ROW_MAX : COL_MAX;
    out_max = cm_q ? COL_MAX : ROW_MAX;
`ifdef MEM_TRAVERSE_SERPENTINE_EN
    in_end  = out_cur[0] ? '0 : in_max;
`else
    in_end  = in_max;
`endif
    in_wrap  = (in_cur == in_end);
    out_wrap = in_wrap && (out_cur == out_max);
    at_last  = out_wrap && (band_q == band_last_q);

    out_nxt = out_cur;
    band_d  = band_q;
    if (in_wrap) begin
      if (out_wrap) begin
        out_nxt = '0;
        band_d  = band_q + BAND_W'(1);
      end else begin
        out_nxt = out_cur + IDX_W'(1);
      end
    end
`ifdef MEM_TRAVERSE_SERPENTINE_EN
    if (in_wrap)         in_nxt = out_nxt[0] ? in_max : '0;
    else if (out_cur[0]) in_nxt = in_cur - IDX_W'(1);
    else                 in_nxt = in_cur + IDX_W'(1);
`else
    in_nxt = in_wrap ? '0 : in_cur + IDX_W'(1);
`endif
    col_d = cm_q ? COL_W'(out_nxt) : COL_W'(in_nxt);
    row_d = cm_q ? ROW_W'(in_nxt)  : ROW_W'(out_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      band_q      <= '0;
      band_last_q <= '0;
      cm_q        <= 1'b0;
      wrap_row_q  <= 1'b0;
      wrap_band_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wrap_row_q  <= 1'b0;
      wrap_band_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tif.start) begin
            if (tif.band_first <= tif.band_last) begin
              col_q       <= '0;
              row_q       <= '0;
              band_q      <= tif.band_first;
              band_last_q <= tif.band_last;
              cm_q        <= tif.col_major;
              state_q     <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tif.abort) begin
            state_q <= IDLE;
          end else if (tif.step) begin
            wrap_row_q <= in_wrap;
            // The final element holds its indices so band never steps past band_last.
            if (at_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              col_q       <= col_d;
              row_q       <= row_d;
              band_q      <= band_d;
              wrap_band_q <= out_wrap;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tif.busy      = (state_q != IDLE);
  assign tif.valid     = (state_q == RUN);
  assign tif.col       = col_q;
  assign tif.row       = row_q;
  assign tif.band      = band_q;
  assign tif.addr      = {band_q, row_q, col_q};
  assign tif.last      = (state_q == RUN) && at_last;
  assign tif.wrap_row  = wrap_row_q;
  assign tif.wrap_band = wrap_band_q;
  assign tif.done      = done_q;
  assign tif.err       = err_q;

endmodule

// File: tb/tb_mem_traverse_gen.sv
// Scoreboard bench for mem_traverse_gen: a nested-loop model queues the expected
// element list, a negedge monitor pops and compares it as the DUT accepts steps.
module tb_mem_traverse_gen;
  localparam int COL_W = 2, ROW_W = 2, BAND_W = 4;
  localparam int NC = 4, NR = 3;
  localparam int AW = BAND_W + ROW_W + COL_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_traverse_gen_if #(.COL_W(COL_W), .ROW_W(ROW_W), .BAND_W(BAND_W)) tif ();

  mem_traverse_gen #(
    .COL_W(COL_W), .ROW_W(ROW_W), .BAND_W(BAND_W),
    .NUM_COLS(NC), .NUM_ROWS(NR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tif  (tif)
  );

  typedef struct {
    logic [AW-1:0] a;
    bit            last;
    bit            wr;
    bit            wb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t e5;
  bit   pat [0:1999];
  int   tot = 0, bad = 0, cyc = 0;
  int   wr_cnt = 0, wb_cnt = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit serp();
`ifdef MEM_TRAVERSE_SERPENTINE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected traversal as plain nested loops over band, outer and inner index.
  task automatic build(input int bf, input int bl, input bit cm);
    int imax, omax, inr, c, r;
    bit first;
    exp_t e;
    imax  = cm ? NR - 1 : NC - 1;
    omax  = cm ? NC - 1 : NR - 1;
    first = 1'b1;
    for (int b = bf; b <= bl; b++)
      for (int o = 0; o <= omax; o++)
        for (int k = 0; k <= imax; k++) begin
          inr    = (serp() && (o % 2 == 1)) ? imax - k : k;
          c      = cm ? o : inr;
          r      = cm ? inr : o;
          e.a    = AW'(b * 16 + r * 4 + c);
          e.wr   = (k == 0) && !first;
          e.wb   = (k == 0) && (o == 0) && (b != bf);
          e.last = (b == bl) && (o == omax) && (k == imax);
          exp_q.push_back(e);
          first  = 1'b0;
        end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (tif.wrap_row)  wr_cnt++;
      if (tif.wrap_band) wb_cnt++;
      if (tif.done)      done_cnt++;
      if (tif.valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q[0];
          chk("elem", {tif.band, tif.row, tif.col}, mon_e.a);
          chk("addr", tif.addr, mon_e.a);
          chk("last", tif.last, mon_e.last);
          if (tif.wrap_row)  chk("wrap_row_pos", mon_e.wr, 1);
          if (tif.wrap_band) chk("wrap_band_pos", mon_e.wb, 1);
          if (tif.step && !tif.abort) void'(exp_q.pop_front());
        end
      end else begin
        chk("last_without_valid", tif.last, 0);
      end
    end
  end

  // mode 0: step held high, 1: step 1,0,0 repeating, 2: random step.
  task automatic run_trav(input int bf, input int bl, input bit cm, input int mode);
    int n, acc, ilast, c0, dcyc, wr0, wb0, d0;
    bit got;
    n = (bl - bf + 1) * NR * NC;
    build(bf, bl, cm);
    for (int i = 0; i < 2000; i++)
      pat[i] = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 3 == 0) : 1'($urandom_range(0, 1));
    acc = 0; ilast = -1;
    for (int i = 0; i < 2000 && acc < n; i++)
      if (pat[i]) begin
        acc++;
        if (acc == n) ilast = i;
      end
    wr0 = wr_cnt; wb0 = wb_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    tif.start = 1'b1; tif.band_first = BAND_W'(bf); tif.band_last = BAND_W'(bl);
    tif.col_major = cm; c0 = cyc;
    @(posedge clk); #1;
    tif.start = 1'b0; tif.step = pat[0];
    got = 1'b0; dcyc = -1;
    for (int t = 0; t < 1990 && !got; t++) begin
      @(negedge clk);
      if (tif.done) begin
        got  = 1'b1;
        dcyc = cyc;
        chk("busy_at_done", tif.busy, 1);
      end else begin
        @(posedge clk); #1;
        tif.step = pat[cyc - c0 - 1];
      end
    end
    tif.step = 1'b0;
    chk("done_seen", got, 1);
    chk("done_cycle", dcyc - c0, ilast + 2);
    @(negedge clk);
    chk("busy_after_done", tif.busy, 0);
    chk("done_width", tif.done, 0);
    chk("wrap_row_cnt", wr_cnt - wr0, (bl - bf + 1) * (cm ? NC : NR));
    chk("wrap_band_cnt", wb_cnt - wb0, bl - bf);
    chk("done_cnt", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bf, bl;
    reset = 1'b1;
    tif.start = 1'b0; tif.abort = 1'b0; tif.step = 1'b0; tif.col_major = 1'b0;
    tif.band_first = '0; tif.band_last = '0;
    #12;
    chk("rst_busy", tif.busy, 0);
    chk("rst_valid", tif.valid, 0);
    chk("rst_addr", tif.addr, 0);
    chk("rst_done", tif.done, 0);
    chk("rst_err", tif.err, 0);
    @(posedge clk); #1 reset = 1'b0;

    run_trav(1, 2, 1'b0, 0);
    run_trav(0, 0, 1'b1, 0);
    run_trav(1, 2, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      bf = $urandom_range(0, 3);
      bl = bf + $urandom_range(0, 2);
      run_trav(bf, bl, 1'($urandom_range(0, 1)), 2);
    end

    // Abort together with step after five accepted elements.
    build(0, 0, 1'b0);
    e5 = exp_q[5];
    @(posedge clk); #1;
    tif.start = 1'b1; tif.band_first = '0; tif.band_last = '0; tif.col_major = 1'b0;
    @(posedge clk); #1;
    tif.start = 1'b0; tif.step = 1'b1;
    repeat (5) @(posedge clk);
    #1 tif.abort = 1'b1;
    @(posedge clk); #1;
    tif.abort = 1'b0; tif.step = 1'b0;
    exp_q.delete();
    chk("abort_valid", tif.valid, 0);
    chk("abort_busy", tif.busy, 0);
    chk("abort_done", tif.done, 0);
    chk("abort_wrap", tif.wrap_row, 0);
    chk("abort_addr_held", tif.addr, e5.a);
    run_trav(0, 0, 1'b0, 0);

    // Rejected start.
    @(posedge clk); #1;
    tif.start = 1'b1; tif.band_first = 4'd3; tif.band_last = 4'd2;
    @(posedge clk); #1;
    tif.start = 1'b0;
    chk("err_pulse", tif.err, 1);
    chk("err_busy", tif.busy, 0);
    chk("err_valid", tif.valid, 0);
    @(posedge clk); #1;
    chk("err_width", tif.err, 0);
    chk("err_busy_after", tif.busy, 0);

    // Reset in the middle of a run, checked before the next clock edge.
    build(0, 1, 1'b0);
    @(posedge clk); #1;
    tif.start = 1'b1; tif.band_first = '0; tif.band_last = 4'd1;
    @(posedge clk); #1;
    tif.start = 1'b0; tif.step = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", tif.busy, 0);
    chk("mid_rst_valid", tif.valid, 0);
    chk("mid_rst_addr", tif.addr, 0);
    chk("mid_rst_col", tif.col, 0);
    chk("mid_rst_last", tif.last, 0);
    chk("mid_rst_wraps", {tif.wrap_row, tif.wrap_band}, 0);
    chk("mid_rst_done_err", {tif.done, tif.err}, 0);
    tif.step = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    run_trav(2, 3, 1'b1, 0);

`ifdef MEM_TRAVERSE_SERPENTINE_EN
    run_trav(0, 0, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
